imm_gen_pipe: RTL



---
 rtl/imm_defs.sv | 34 +++
 rtl/imm_lane_dec.sv | 95 +++++++++
 rtl/imm_gen_pipe.sv | 123 ++++++++++++
 3 files changed

// File: rtl/imm_defs.sv
// Shared definitions for the immediate generator: RISC-V major opcodes,
// format tag encoding and a funct3 helper for shift-immediate detection.
package imm_defs;

  localparam int unsigned IMM_FMT_W = 3;

  // Major opcodes, inst[6:0]
  localparam logic [6:0] OPC_LOAD        = 7'b0000011;
  localparam logic [6:0] OPC_ARI_ITYPE   = 7'b0010011;
  localparam logic [6:0] OPC_ARI_ITYPE32 = 7'b0011011;
  localparam logic [6:0] OPC_AUIPC       = 7'b0010111;
  localparam logic [6:0] OPC_STORE       = 7'b0100011;
  localparam logic [6:0] OPC_LUI         = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH      = 7'b1100011;
  localparam logic [6:0] OPC_JALR        = 7'b1100111;
  localparam logic [6:0] OPC_JAL         = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM      = 7'b1110011;

  // Format tags
  localparam logic [IMM_FMT_W-1:0] IMM_FMT_NONE  = 3'd0;
  localparam logic [IMM_FMT_W-1:0] IMM_FMT_I     = 3'd1;
  localparam logic [IMM_FMT_W-1:0] IMM_FMT_S     = 3'd2;
  localparam logic [IMM_FMT_W-1:0] IMM_FMT_B     = 3'd3;
  localparam logic [IMM_FMT_W-1:0] IMM_FMT_J     = 3'd4;
  localparam logic [IMM_FMT_W-1:0] IMM_FMT_U     = 3'd5;
  localparam logic [IMM_FMT_W-1:0] IMM_FMT_CSR   = 3'd6;
  localparam logic [IMM_FMT_W-1:0] IMM_FMT_SHAMT = 3'd7;

  // funct3 of SLLI / SRLI / SRAI (and their -W variants)
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_lane_dec.sv
// Single-lane combinational immediate decoder.
// Ports:
//   inst    - 32-bit instruction
//   lane_en - lane enable; when low the lane decodes to imm=0, fmt=NONE
//   imm     - XLEN-wide immediate
//   fmt     - format tag (IMM_FMT_*)
module imm_lane_dec
  import imm_defs::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]          inst,
  input  logic                 lane_en,
  output logic [XLEN-1:0]      imm,
  output logic [IMM_FMT_W-1:0] fmt
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic [XLEN-1:0] sign;

  assign opc    = inst[6:0];
  assign funct3 = inst[14:12];
  assign sign   = {XLEN{inst[31]}};

  // Sign-extended forms start from an all-sign word and overwrite the low bits,
  // which keeps the same code valid for XLEN=32 and XLEN=64.
  always_comb begin
    imm = '0;
    fmt = IMM_FMT_NONE;
    if (lane_en) begin
      case (opc)
        OPC_JALR, OPC_LOAD: begin
          imm       = sign;
          imm[11:0] = inst[31:20];
          fmt       = IMM_FMT_I;
        end
        OPC_ARI_ITYPE: begin
          if (is_shift(funct3)) begin
            imm[SHAMT_W-1:0] = inst[20 +: SHAMT_W];
            fmt              = IMM_FMT_SHAMT;
          end else begin
            imm       = sign;
            imm[11:0] = inst[31:20];
            fmt       = IMM_FMT_I;
          end
        end
        OPC_ARI_ITYPE32: begin
          // -W ops only exist on RV64; on RV32 the opcode is not an immediate form
          if (XLEN == 64) begin
            if (is_shift(funct3)) begin
              imm[4:0] = inst[24:20];
              fmt      = IMM_FMT_SHAMT;
            end else begin
              imm       = sign;
              imm[11:0] = inst[31:20];
              fmt       = IMM_FMT_I;
            end
          end
        end
        OPC_STORE: begin
          imm       = sign;
          imm[11:0] = {inst[31:25], inst[11:7]};
          fmt       = IMM_FMT_S;
        end
        OPC_BRANCH: begin
          imm       = sign;
          imm[12:0] = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
          fmt       = IMM_FMT_B;
        end
        OPC_JAL: begin
          imm       = sign;
          imm[20:0] = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
          fmt       = IMM_FMT_J;
        end
        OPC_LUI, OPC_AUIPC: begin
          imm       = sign;
          imm[31:0] = {inst[31:12], 12'b0};
          fmt       = IMM_FMT_U;
        end
        OPC_SYSTEM: begin
          imm[4:0] = inst[19:15];
          fmt      = IMM_FMT_CSR;
        end
        default: begin
          imm = '0;
          fmt = IMM_FMT_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined multi-lane immediate generator for the ID stage.
// Decodes LANES instructions per beat into a registered output stage backed by
// a one-entry skid buffer, so the consumer can stall without losing beats.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush                 - synchronous flush, drops all buffered and incoming beats
//   in_valid / in_ready   - input handshake; in_ready is registered
//   in_inst, in_lane_en   - LANES instructions (lane i at [32*i +: 32]) and enables
//   out_valid / out_ready - output handshake
//   out_imm, out_fmt      - per-lane immediate and format tag
//   out_lane_en           - registered copy of in_lane_en
module imm_gen_pipe
  import imm_defs::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned LANES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*32-1:0]        in_inst,
  input  logic [LANES-1:0]           in_lane_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*XLEN-1:0]      out_imm,
  output logic [LANES*IMM_FMT_W-1:0] out_fmt,
  output logic [LANES-1:0]           out_lane_en
);

  logic [LANES*XLEN-1:0]      dec_imm;
  logic [LANES*IMM_FMT_W-1:0] dec_fmt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    imm_lane_dec #(
      .XLEN(XLEN)
    ) u_dec (
      .inst    (in_inst[32*i +: 32]),
      .lane_en (in_lane_en[i]),
      .imm     (dec_imm[XLEN*i +: XLEN]),
      .fmt     (dec_fmt[IMM_FMT_W*i +: IMM_FMT_W])
    );
  end

  logic                       out_valid_q, out_valid_d;
  logic [LANES*XLEN-1:0]      out_imm_q;
  logic [LANES*IMM_FMT_W-1:0] out_fmt_q;
  logic [LANES-1:0]           out_en_q;
  logic                       skid_valid_q, skid_valid_d;
  logic [LANES*XLEN-1:0]      skid_imm_q;
  logic [LANES*IMM_FMT_W-1:0] skid_fmt_q;
  logic [LANES-1:0]           skid_en_q;

  logic accept, out_free;
  logic out_load_dec, out_load_skid, skid_load;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  // in_ready is low whenever skid holds data, so a skid refill and a fresh
  // accept can never compete for the output register.
  always_comb begin
    out_valid_d   = out_valid_q;
    skid_valid_d  = skid_valid_q;
    out_load_dec  = 1'b0;
    out_load_skid = 1'b0;
    skid_load     = 1'b0;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_load_skid = 1'b1;
        out_valid_d   = 1'b1;
        skid_valid_d  = 1'b0;
      end else begin
        out_load_dec = accept;
        out_valid_d  = accept;
      end
    end else if (accept) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= '0;
      out_en_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= '0;
      skid_en_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      if (out_load_skid) begin
        out_imm_q <= skid_imm_q;
        out_fmt_q <= skid_fmt_q;
        out_en_q  <= skid_en_q;
      end else if (out_load_dec) begin
        out_imm_q <= dec_imm;
        out_fmt_q <= dec_fmt;
        out_en_q  <= in_lane_en;
      end
      if (skid_load) begin
        skid_imm_q <= dec_imm;
        skid_fmt_q <= dec_fmt;
        skid_en_q  <= in_lane_en;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_lane_en = out_en_q;

endmodule
